// File: rtl/npu_mac_window.sv
// Windowed multiply-accumulate over two activation/weight pairs per beat, with
// requantisation to an unsigned byte and a one-entry ready/valid result register.
module npu_mac_window #(
    parameter int TAPS  = 9,
    parameter int ACC_W = 20,
    parameter int SHIFT = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [7:0]                             data0,
    input  logic [7:0]                             data1,
    input  logic [7:0]                             data2,
    input  logic [7:0]                             data3,
    input  logic                                   flush,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [ACC_W-1:0]                acc_out,
    output logic [7:0]                             out_data,
    output logic [$clog2(((TAPS+1)/2)+1)-1:0]      beat_cnt
);

    localparam int BEATS = (TAPS + 1) / 2;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam bit TAPS_ODD = (TAPS % 2) == 1;
    localparam logic signed [ACC_W-1:0] U8_MAX = ACC_W'(255);

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;

    logic signed [16:0]      prod_a;
    logic signed [16:0]      prod_b;
    logic signed [ACC_W-1:0] ext_a;
    logic signed [ACC_W-1:0] ext_b;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] beat_sum;
    logic                    accept;
    logic                    last_beat;
    logic                    drop_b;

    function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] value);
        logic signed [ACC_W-1:0] shifted;
        shifted = value >>> SHIFT;
        if (shifted < 0)
            requant = 8'd0;
        else if (shifted > U8_MAX)
            requant = 8'hFF;
        else
            requant = shifted[7:0];
    endfunction

    // A stalled result blocks new beats so a completing window never overwrites it.
    assign in_ready  = !(out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign drop_b    = last_beat && TAPS_ODD;

    // Activations are unsigned bytes: a zero MSB keeps them positive in the signed multiply.
    assign prod_a = $signed({1'b0, data0}) * $signed(data1);
    assign prod_b = $signed({1'b0, data2}) * $signed(data3);
    assign ext_a  = ACC_W'(prod_a);
    assign ext_b  = ACC_W'(prod_b);

    // NOTE: every always_comb output gets a default before any condition so no latch is inferred.
    always_comb begin
        acc_base = acc;
        if (state == ST_IDLE)
            acc_base = '0;
        beat_sum = acc_base + ext_a;
        if (!drop_b)
            beat_sum = beat_sum + ext_b;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            // flush wins over a beat on the same edge, and never touches the result register.
            if (flush) begin
                state    <= ST_IDLE;
                acc      <= '0;
                beat_cnt <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    acc_out   <= beat_sum;
                    out_data  <= requant(beat_sum);
                    out_valid <= 1'b1;
                    acc       <= '0;
                    beat_cnt  <= '0;
                    state     <= ST_IDLE;
                end else begin
                    acc       <= beat_sum;
                    beat_cnt  <= beat_cnt + CNT_W'(1);
                    state     <= ST_ACCUM;
                end
            end
        end
    end

endmodule
